// File: rtl/crypto_mul_arbiter.sv
// crypto_mul_arbiter: round-robin arbiter sharing one external 16x16->32
// unsigned multiplier between NUM_REQ requesters. The product and requester
// ID are captured in a one-entry output stage with valid/ready handshake.
// Optional macro CRYPTO_MUL_ARB_STATS_EN adds saturating grant/stall counters.
module crypto_mul_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [16*NUM_REQ-1:0]   req_din0,
  input  logic [16*NUM_REQ-1:0]   req_din1,
  output logic [15:0]             mul_din0,
  output logic [15:0]             mul_din1,
  input  logic [31:0]             mul_dout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [31:0]             rsp_data,
  output logic [ID_W-1:0]         rsp_id
`ifdef CRYPTO_MUL_ARB_STATS_EN
  ,
  output logic [31:0]             stat_grants,
  output logic [31:0]             stat_stalls
`endif
);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [31:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0] rsp_id_q, rsp_id_d;

  logic            accept;
  logic            fire;
  logic [ID_W-1:0] grant_idx;
  int unsigned     scan_idx;

  // Round-robin scan starting at rr_ptr; outputs forced low while in reset
  // so nothing is granted before the state register is released.
  always_comb begin
    accept    = ap_rst_n && ((state_q == S_EMPTY) || rsp_ready);
    fire      = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    if (accept) begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        scan_idx = 32'(rr_ptr_q) + k;
        if (scan_idx >= NUM_REQ) begin
          scan_idx = scan_idx - NUM_REQ;
        end
        if (!fire && req_valid[scan_idx]) begin
          fire      = 1'b1;
          grant_idx = ID_W'(scan_idx);
        end
      end
    end
    if (fire) begin
      req_ready[grant_idx] = 1'b1;
      mul_din0 = req_din0[32'(grant_idx)*16 +: 16];
      mul_din1 = req_din1[32'(grant_idx)*16 +: 16];
    end
  end

  // Next-state: a fire reloads the output stage (even while it is being
  // drained), otherwise a drain empties it.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    if (fire) begin
      state_d    = S_FULL;
      rsp_data_d = mul_dout;
      rsp_id_d   = grant_idx;
      if (32'(grant_idx) == NUM_REQ - 1) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = grant_idx + 1'b1;
      end
    end else if ((state_q == S_FULL) && rsp_ready) begin
      state_d = S_EMPTY;
    end
  end

  // Output stage and arbitration pointer registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= S_EMPTY;
      rr_ptr_q   <= '0;
      rsp_data_q <= '0;
      rsp_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
    end
  end

  assign rsp_valid = (state_q == S_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;

`ifdef CRYPTO_MUL_ARB_STATS_EN
  logic [31:0] stat_grants_q, stat_grants_d;
  logic [31:0] stat_stalls_q, stat_stalls_d;

  // Saturating counters for fires and blocked-while-full cycles.
  always_comb begin
    stat_grants_d = stat_grants_q;
    stat_stalls_d = stat_stalls_q;
    if (fire && (stat_grants_q != '1)) begin
      stat_grants_d = stat_grants_q + 32'd1;
    end
    if ((state_q == S_FULL) && !rsp_ready && (|req_valid) && (stat_stalls_q != '1)) begin
      stat_stalls_d = stat_stalls_q + 32'd1;
    end
  end

  // Statistics registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_grants_q <= '0;
      stat_stalls_q <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stalls_q <= stat_stalls_d;
    end
  end

  assign stat_grants = stat_grants_q;
  assign stat_stalls = stat_stalls_q;
`endif

endmodule
